uart_tx_scheduler: RTL and testbench

//  Shares one UART byte transmitter (start/8 data/parity/stop framer with isStart/isFinish handshake)

---
 rtl/uart_tx_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte framer among N_REQ producers.
// Generates the baud tick, sequences start/finish and aborts a stuck framer.
module uart_tx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int CLK_DIV   = 5208,
    parameter int GAP_TICKS = 1,
    parameter int TMO_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               snd_enable,
    output logic               snd_start,
    output logic [7:0]         snd_data,
    input  logic               snd_finish
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int TMAX  = (TMO_TICKS > GAP_TICKS) ? TMO_TICKS : GAP_TICKS;
    localparam int TW    = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARMED,
        WAIT_DONE,
        GAP
    } state_t;

    state_t state;
    state_t nextState;

    logic [CNT_W-1:0] cnt;
    logic [TW-1:0]    tickCnt;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  cand;
    logic             pickValid;
    logic             capture;
    logic             finishOk;
    logic             timeout;
    logic             tmoHit;
    logic [7:0]       dataArr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            dataArr[i] = data[8*i +: 8];
        end
    end

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        pick      = '0;
        cand      = '0;
        pickValid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                pick      = cand;
                pickValid = 1'b1;
            end
        end
    end

    assign tmoHit = snd_enable && (int'(tickCnt) == TMO_TICKS - 1);
    assign busy   = (state != IDLE);

    always_comb begin
        nextState = state;
        capture   = 1'b0;
        finishOk  = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pickValid) begin
                    nextState = LAUNCH;
                    capture   = 1'b1;
                end
            end
            LAUNCH: begin
                if (snd_enable) nextState = ARMED;
            end
            ARMED: begin
                if (!snd_finish) begin
                    nextState = WAIT_DONE;
                end else if (tmoHit) begin
                    nextState = GAP;
                    timeout   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (snd_finish) begin
                    nextState = GAP;
                    finishOk  = 1'b1;
                end else if (tmoHit) begin
                    nextState = GAP;
                    timeout   = 1'b1;
                end
            end
            GAP: begin
                if (GAP_TICKS == 0) begin
                    nextState = IDLE;
                end else if (snd_enable &&
                             int'(tickCnt) == GAP_TICKS - 1) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            snd_enable <= 1'b0;
        end else begin
            cnt        <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
            snd_enable <= (cnt == CNT_W'(CLK_DIV - 2));
        end
    end

    // One counter serves both the watchdog and the inter-frame gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickCnt <= '0;
        end else if (nextState != state &&
                     (nextState == ARMED || nextState == GAP)) begin
            tickCnt <= '0;
        end else if (snd_enable && tickCnt != '1 &&
                     (state == ARMED || state == WAIT_DONE ||
                      state == GAP)) begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            done      <= '0;
            err       <= 1'b0;
            grant_id  <= '0;
            snd_start <= 1'b0;
            snd_data  <= '0;
            last      <= ID_W'(N_REQ - 1);
        end else begin
            ack  <= '0;
            done <= '0;
            err  <= 1'b0;
            if (capture) begin
                snd_data   <= dataArr[pick];
                grant_id   <= pick;
                last       <= pick;
                ack[pick]  <= 1'b1;
                snd_start  <= 1'b1;
            end
            if (state == ARMED && !snd_finish) begin
                snd_start <= 1'b0;
            end
            if (timeout) begin
                snd_start <= 1'b0;
                err       <= 1'b1;
            end
            if (finishOk) begin
                done[grant_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural byte framer.
// Fast baud (CLK_DIV=4) keeps whole frames short.
module tb_uart_tx_scheduler;

    localparam int N_REQ     = 4;
    localparam int ID_W      = 2;
    localparam int CLK_DIV   = 4;
    localparam int GAP_TICKS = 1;
    localparam int TMO_TICKS = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [8*N_REQ-1:0] data = '0;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   done;
    logic               err;
    logic               busy;
    logic [ID_W-1:0]    grant_id;
    logic               snd_enable;
    logic               snd_start;
    logic [7:0]         snd_data;
    logic               snd_finish;

    logic stuck = 1'b0;
    int   bitCnt;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ     (N_REQ),
        .ID_W      (ID_W),
        .CLK_DIV   (CLK_DIV),
        .GAP_TICKS (GAP_TICKS),
        .TMO_TICKS (TMO_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .snd_enable (snd_enable),
        .snd_start  (snd_start),
        .snd_data   (snd_data),
        .snd_finish (snd_finish)
    );

    // Framer: start sampled on a tick, finish low for 11 ticks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_finish <= 1'b1;
            bitCnt     <= 0;
        end else if (snd_enable) begin
            if (snd_finish && snd_start && !stuck) begin
                snd_finish <= 1'b0;
                bitCnt     <= 0;
            end else if (!snd_finish) begin
                if (bitCnt == 10) snd_finish <= 1'b1;
                else              bitCnt <= bitCnt + 1;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitGrant(input int idx, input logic [7:0] d);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        check("ackSeen", 32'(got), 1);
        check("ackVec", 32'(ack), 32'(1 << idx));
        check("grantId", 32'(grant_id), 32'(idx));
        check("sndData", 32'(snd_data), 32'(d));
    endtask

    task automatic waitFinish(input int idx);
        logic got;
        int   extraAck;
        int   errSeen;
        got      = 1'b0;
        extraAck = 0;
        errSeen  = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) extraAck++;
            if (err) errSeen++;
            if (done != '0) got = 1'b1;
        end
        check("doneSeen", 32'(got), 1);
        check("doneVec", 32'(done), 32'(1 << idx));
        check("extraAck", 32'(extraAck), 0);
        check("errInFrame", 32'(errSeen), 0);
    endtask

    task automatic waitIdle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
        end
        check("backToIdle", 32'(got), 1);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_gid"}, 32'(grant_id), 0);
        check({tag, "_en"}, 32'(snd_enable), 0);
        check({tag, "_start"}, 32'(snd_start), 0);
        check({tag, "_data"}, 32'(snd_data), 0);
    endtask

    initial begin
        logic gotStart;
        logic gotErr;
        int   ticks;
        int   doneCnt;

        #1 rst_n = 1'b0;
        #11;
        checkAllZero("reset");

        // Baud tick: cnt reaches 3 after 3 edges, then every 4.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("enPhase", 32'(snd_enable), 32'((k % 4) == 3));
        end
        check("idleBusy", 32'(busy), 0);

        // Single request from requester 0.
        data = 32'h000000A5;
        req  = 4'b0001;
        waitGrant(0, 8'hA5);
        req = '0;
        check("t1Start", 32'(snd_start), 1);
        check("t1Busy", 32'(busy), 1);
        gotStart = 1'b0;
        for (int i = 0; i < 100 && !gotStart; i++) begin
            @(negedge clk);
            if (!snd_start) gotStart = 1'b1;
        end
        check("t1StartDrop", 32'(gotStart), 1);
        check("t1FinLow", 32'(snd_finish), 0);
        waitFinish(0);
        waitIdle();

        // All requesters held: strict rotation starting at 0.
        rst_n = 1'b0;
        #1;
        data = 32'h44332211;
        req  = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        waitGrant(0, 8'h11);
        waitFinish(0);
        waitGrant(1, 8'h22);
        waitFinish(1);
        waitGrant(2, 8'h33);
        waitFinish(2);
        waitGrant(3, 8'h44);
        waitFinish(3);
        waitGrant(0, 8'h11);
        waitFinish(0);
        req = '0;
        waitIdle();

        // Two held requesters alternate once both are pending.
        req = 4'b0010;
        waitGrant(1, 8'h22);
        req = 4'b0110;
        waitFinish(1);
        waitGrant(2, 8'h33);
        waitFinish(2);
        waitGrant(1, 8'h22);
        waitFinish(1);
        waitGrant(2, 8'h33);
        req = '0;
        waitFinish(2);
        waitIdle();

        // Stuck framer: abort after 16 ticks in ARMED.
        stuck = 1'b1;
        data  = 32'h0000005A;
        req   = 4'b0001;
        waitGrant(0, 8'h5A);
        req     = '0;
        ticks   = snd_enable ? 1 : 0;
        doneCnt = 0;
        gotErr  = 1'b0;
        for (int i = 0; i < 200 && !gotErr; i++) begin
            @(negedge clk);
            if (done != '0) doneCnt++;
            if (err) gotErr = 1'b1;
            else if (snd_enable) ticks++;
        end
        check("t4ErrSeen", 32'(gotErr), 1);
        check("t4Ticks", 32'(ticks), 17);
        check("t4StartLow", 32'(snd_start), 0);
        check("t4NoDone", 32'(doneCnt), 0);
        @(negedge clk);
        check("t4ErrPulse", 32'(err), 0);
        waitIdle();
        stuck = 1'b0;

        // Asynchronous reset in the middle of a frame.
        data = 32'h000000C3;
        req  = 4'b0001;
        waitGrant(0, 8'hC3);
        req = '0;
        repeat (10) @(negedge clk);
        check("t5BusyBefore", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("asyncRst");
        data = 32'h44332211;
        req  = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        waitGrant(0, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
